// File: rtl/sl_preceptron_pkg.sv
// -----------------------------------------------------------------------------
// sl_preceptron_pkg
//   Shared definitions for the perceptron job scheduler: the controller state
//   encoding and the default widths of the beat-length and sum/threshold fields.
//   Imported by the bus interface and by the scheduler top.
// -----------------------------------------------------------------------------
package sl_preceptron_pkg;

    localparam int unsigned DEF_LEN_WIDTH = 16;
    localparam int unsigned DEF_SUM_WIDTH = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

endpackage

// File: rtl/sl_preceptron_sched_if.sv
// -----------------------------------------------------------------------------
// sl_preceptron_sched_if
//   Bundles the host command channel, the data-beat strobe, the MAC control and
//   status lines and the result channel of the perceptron scheduler.
//   Modports:
//     master : the scheduler (drives cmd_ready, mac_*, res_valid/sum/cmp/timeout)
//     slave  : the environment (host, MAC and result consumer)
//   Signals:
//     cmd_valid/cmd_ready, cmd_len[LEN_WIDTH], cmd_threshold[SUM_WIDTH]
//     data_valid
//     mac_start, mac_done, mac_threshold[SUM_WIDTH], mac_sum[SUM_WIDTH], mac_cmp
//     res_valid/res_ready, res_sum[SUM_WIDTH], res_cmp, res_timeout
// -----------------------------------------------------------------------------
interface sl_preceptron_sched_if
    import sl_preceptron_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int unsigned SUM_WIDTH = DEF_SUM_WIDTH
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic [SUM_WIDTH-1:0] cmd_threshold;

    logic                 data_valid;

    logic                 mac_start;
    logic                 mac_done;
    logic [SUM_WIDTH-1:0] mac_threshold;
    logic [SUM_WIDTH-1:0] mac_sum;
    logic                 mac_cmp;

    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_WIDTH-1:0] res_sum;
    logic                 res_cmp;
    logic                 res_timeout;

    modport master (
        input  cmd_valid, cmd_len, cmd_threshold, data_valid,
               mac_sum, mac_cmp, res_ready,
        output cmd_ready, mac_start, mac_done, mac_threshold,
               res_valid, res_sum, res_cmp, res_timeout
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_threshold, data_valid,
               mac_sum, mac_cmp, res_ready,
        input  cmd_ready, mac_start, mac_done, mac_threshold,
               res_valid, res_sum, res_cmp, res_timeout
    );

endinterface

// File: rtl/sl_preceptron_sched.sv
// -----------------------------------------------------------------------------
// sl_preceptron_sched
//   Job scheduler wrapped around an external perceptron MAC. A host command
//   (length, threshold) is accepted in IDLE, the MAC is started with a one-cycle
//   pulse, data beats are counted in RUN, the MAC is told the vector is done,
//   the MAC status is given RESULT_LAT cycles to settle and is then captured and
//   offered on the result channel until the consumer takes it.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : sl_preceptron_sched_if.master (command, data strobe, MAC, result)
//     busy   : high whenever the controller is not in IDLE
//
//   Optional feature (macro SL_PRECEPTRON_SCHED_TIMEOUT_EN):
//     When defined, TIMEOUT_CYCLES consecutive RUN cycles without data_valid end
//     the job early and the result is flagged with res_timeout. When undefined
//     there is no stall counter, res_timeout is 0 and RUN waits indefinitely.
// -----------------------------------------------------------------------------
module sl_preceptron_sched
    import sl_preceptron_pkg::*;
#(
    parameter int unsigned VECTOR_LENGTH  = 64,
    parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int unsigned SUM_WIDTH      = DEF_SUM_WIDTH,
    parameter int unsigned RESULT_LAT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sl_preceptron_sched_if.master        bus,
    output logic                         busy
);

    // One extra bit so the counter can reach an all-ones length without wrapping.
    localparam int unsigned CNT_W = LEN_WIDTH + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t VEC_LEN_C = cnt_t'(VECTOR_LENGTH);

    localparam int unsigned DRAIN_W = $clog2(RESULT_LAT + 2);
    typedef logic [DRAIN_W-1:0] drain_t;
    localparam drain_t DRAIN_LAST = drain_t'(RESULT_LAT);

    if (VECTOR_LENGTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sl_preceptron_sched: VECTOR_LENGTH and TIMEOUT_CYCLES must be >= 1");
    end

    state_e               state_q;
    logic                 cmd_ready_q;
    cnt_t                 len_q;
    cnt_t                 cnt_q;
    drain_t               drain_q;
    logic [SUM_WIDTH-1:0] thr_q;
    logic                 mac_start_q;
    logic                 mac_done_q;
    logic                 res_valid_q;
    logic [SUM_WIDTH-1:0] res_sum_q;
    logic                 res_cmp_q;

`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef logic [STALL_W-1:0] stall_t;
    // stall_q holds the idle cycles already seen, so the limit is hit on the
    // cycle where one more idle cycle would make TIMEOUT_CYCLES.
    localparam stall_t STALL_LAST = stall_t'(TIMEOUT_CYCLES - 1);

    stall_t stall_q;
    logic   to_flag_q;
    logic   res_to_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            thr_q       <= '0;
            mac_start_q <= 1'b0;
            mac_done_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cmp_q   <= 1'b0;
`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
            stall_q     <= '0;
            to_flag_q   <= 1'b0;
            res_to_q    <= 1'b0;
`endif
        end else begin
            // Start and done are single-cycle pulses by construction.
            mac_start_q <= 1'b0;
            mac_done_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Ready comes up one clock after reset release or after a
                    // result transfer, never combinationally.
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && bus.cmd_valid) begin
                        len_q       <= (bus.cmd_len == '0) ? VEC_LEN_C : cnt_t'(bus.cmd_len);
                        thr_q       <= bus.cmd_threshold;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        mac_start_q <= 1'b1;
                        state_q     <= ST_ARM;
`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
                        stall_q     <= '0;
                        to_flag_q   <= 1'b0;
`endif
                    end
                end

                ST_ARM: begin
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (bus.data_valid) begin
                        cnt_q <= cnt_q + cnt_t'(1);
`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
                        stall_q <= '0;
`endif
                        if (cnt_q + cnt_t'(1) == len_q) begin
                            mac_done_q <= 1'b1;
                            drain_q    <= '0;
                            state_q    <= ST_DRAIN;
                        end
                    end
`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
                    else if (stall_q == STALL_LAST) begin
                        mac_done_q <= 1'b1;
                        to_flag_q  <= 1'b1;
                        drain_q    <= '0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        stall_q <= stall_q + stall_t'(1);
                    end
`endif
                end

                ST_DRAIN: begin
                    // First DRAIN cycle carries mac_done; the status is sampled
                    // RESULT_LAT cycles after that pulse.
                    if (drain_q == DRAIN_LAST) begin
                        res_sum_q   <= bus.mac_sum;
                        res_cmp_q   <= bus.mac_cmp;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESULT;
`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
                        res_to_q    <= to_flag_q;
`endif
                    end else begin
                        drain_q <= drain_q + drain_t'(1);
                    end
                end

                ST_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.mac_start     = mac_start_q;
    assign bus.mac_done      = mac_done_q;
    assign bus.mac_threshold = thr_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_sum       = res_sum_q;
    assign bus.res_cmp       = res_cmp_q;
    assign busy              = (state_q != ST_IDLE);

`ifdef SL_PRECEPTRON_SCHED_TIMEOUT_EN
    assign bus.res_timeout = res_to_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

endmodule

// File: doc/sl_preceptron_sched.md
SL_PRECEPTRON_SCHED -- requirements
Module: sl_preceptron_sched

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 64, the beat count used when cmd_len is 0.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, the width of the beat-length field.
REQ-003 SHALL have parameter SUM_WIDTH, default 22, the width of the threshold and sum fields.
REQ-004 SHALL have parameter RESULT_LAT, default 4, the cycles from the mac_done pulse to the MAC status being stable.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, the stall limit used when the timeout feature is compiled in.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-008 SHALL have port cmd_valid, input, 1 bit, host job request.
REQ-009 SHALL have port cmd_ready, output, 1 bit, job accept.
REQ-010 SHALL have port cmd_len, input, LEN_WIDTH bits, beats in the job; 0 means VECTOR_LENGTH.
REQ-011 SHALL have port cmd_threshold, input, SUM_WIDTH bits, job threshold.
REQ-012 SHALL have port data_valid, input, 1 bit, the data beat strobe sampled in parallel with the MAC.
REQ-013 SHALL have port mac_start, output, 1 bit, one-cycle start pulse to the MAC.
REQ-014 SHALL have port mac_done, output, 1 bit, one-cycle done pulse to the MAC.
REQ-015 SHALL have port mac_threshold, output, SUM_WIDTH bits, the threshold driven to the MAC.
REQ-016 SHALL have port mac_sum, input, SUM_WIDTH bits, the MAC status sum.
REQ-017 SHALL have port mac_cmp, input, 1 bit, the MAC status comparator.
REQ-018 SHALL have port res_valid, output, 1 bit, result available.
REQ-019 SHALL have port res_ready, input, 1 bit, the consumer accepts the result.
REQ-020 SHALL have port res_sum, output, SUM_WIDTH bits, the captured sum.
REQ-021 SHALL have port res_cmp, output, 1 bit, the captured comparator.
REQ-022 SHALL have port res_timeout, output, 1 bit, result aborted by stall.
REQ-023 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-024 SHALL implement the states IDLE, ARM, RUN, DRAIN and RESULT (plus nothing else); cmd_ready SHALL be high only in IDLE.
REQ-025 SHALL latch cmd_len (0 is replaced by VECTOR_LENGTH) and cmd_threshold, then go IDLE->ARM, on cmd_valid&&cmd_ready.
REQ-026 SHALL drive mac_threshold from the latched threshold at all times, so that it is stable during mac_start.
REQ-027 SHALL assert mac_start for exactly the one ARM cycle and then go ARM->RUN.
REQ-028 SHALL, in RUN, increment the beat counter on each data_valid; data_valid outside RUN SHALL be ignored.
REQ-029 SHALL, when the counter reaches the latched length, assert mac_done for one cycle in the next cycle and go RUN->DRAIN.
REQ-030 SHALL hold DRAIN for RESULT_LAT cycles, then capture mac_sum and mac_cmp into res_sum and res_cmp and go DRAIN->RESULT.
REQ-031 SHALL hold res_valid and the result fields stable in RESULT until res_valid&&res_ready, then go RESULT->IDLE.
REQ-032 SHALL NOT raise cmd_ready in the same cycle as a transfer with res_ready; the first cycle cmd_ready can be high is the cycle after that transfer.
REQ-033 SHALL size the beat counter at LEN_WIDTH+1 bits so that it never wraps; a cmd_len of all-ones SHALL be legal.
REQ-034 SHALL never assert mac_start and mac_done together, and SHALL never assert mac_start outside ARM.

Reset
REQ-035 SHALL, on rst_n low at any time including mid-job, go to IDLE immediately and asynchronously and clear the counters and latches.
REQ-036 SHALL hold these values during reset: mac_start, mac_done, res_valid, res_cmp, res_timeout and busy at 0; res_sum and mac_threshold at 0; cmd_ready at 0.
REQ-037 SHALL raise cmd_ready on the first clock after rst_n is released.

Configuration
REQ-038 SHALL, with macro SL_PRECEPTRON_SCHED_TIMEOUT_EN defined, count consecutive RUN cycles without data_valid; on reaching TIMEOUT_CYCLES it SHALL issue mac_done, go to DRAIN and set res_timeout=1 with the result.
REQ-039 SHALL, without SL_PRECEPTRON_SCHED_TIMEOUT_EN, contain no stall counter, tie res_timeout to 0, and wait in RUN indefinitely.

Structure
REQ-040 SHALL place the state enum encoding and the default widths (LEN_WIDTH, SUM_WIDTH) in the shared package sl_preceptron_pkg.
REQ-041 SHALL keep all logic in a single module, with no sub-module.

Verification
REQ-042 SHALL cover: cmd_len=4, threshold=10, with 4 consecutive data_valid beats and mac_sum=25, mac_cmp=1 -> mac_start pulses once, mac_done appears the cycle after beat 4, res_valid rises RESULT_LAT+1 cycles later with res_sum=25 and res_cmp=1.
REQ-043 SHALL cover: cmd_len=0 -> exactly 64 beats are counted before mac_done.
REQ-044 SHALL cover: res_ready held low for 10 cycles -> res_valid and res_sum are stable throughout, cmd_ready stays 0, and cmd_ready rises the cycle after the transfer.
REQ-045 SHALL cover: rst_n pulsed low in RUN after 3 of 8 beats -> all outputs return to their reset values at once, and a new job completes normally afterwards.
REQ-046 SHALL cover: with the macro set and TIMEOUT_CYCLES=16, data stalled after 2 beats -> mac_done appears after 16 idle cycles with res_timeout=1; without the macro the block stays in RUN with busy=1.
